plot_arbiter: RTL and testbench
===============================

// Module: plot_arbiter
// PURPOSE
//  Shares the single framebuffer write port (x, y, color_draw, plot) between two
//  pixel requesters, e.g. the game controller/datapath and an overlay/HUD drawer.
//  Also runs a full-screen clear sweep on request. Sits between the processor and
//  the VGA adapter; one pixel per clock maximum.
// PARAMETERS
//  X_MAX  159  last valid x coordinate (screen width-1)
//  Y_MAX  119  last valid y coordinate (screen height-1)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  req0_valid   in   1  requester 0 has a pixel; payload held until accepted
//  req0_x       in   8  requester 0 x
//  req0_y       in   8  requester 0 y
//  req0_color   in   8  requester 0 colour
//  req0_ready   out  1  requester 0 pixel accepted this cycle (combinational)
//  req1_*       --   -  identical set for requester 1
//  clear_start  in   1  start clear sweep (level sampled in IDLE only)
//  clear_color  in   8  colour for sweep, latched on accepted clear_start
//  clear_busy   out  1  sweep in progress
//  clear_done   out  1  one-cycle pulse after final sweep pixel
//  x, y         out  8  registered pixel coordinates to framebuffer
//  color_draw   out  8  registered pixel colour
//  plot         out  1  registered write strobe
//  grant_id     out  1  requester whose pixel is on the outputs (valid with plot)
// BEHAVIOUR
//  - Reset: x=y=color_draw=0, plot=0, grant_id=0, clear_busy=0, clear_done=0,
//    state=IDLE, last-grant pointer=1 (req0 wins first tie). Reset mid-sweep aborts
//    it; no clear_done.
//  - FSM: IDLE, CLEAR.
//  - IDLE, clear_start=1: wins over any valid; both readys 0; next edge: state=CLEAR,
//    clear_busy=1, outputs=(0,0,clear_color), plot=1, internal counter -> (1,0).
//  - IDLE, no clear: ready to one valid requester; if both valid, grant to one not
//    granted last (round-robin); pointer updates on each transfer. Transfer =
//    valid&&ready. Next edge: outputs=payload, plot=1, grant_id=id. Latency 1.
//    Back-to-back transfers: plot stays high every cycle. No transfer -> plot=0,
//    x/y/color_draw hold.
//  - CLEAR: readys 0, clear_start ignored; one pixel per cycle, row-major
//    (x 0..X_MAX, then y++); after (X_MAX,Y_MAX) plotted: next edge plot=0,
//    clear_busy=0, clear_done=1 for one cycle, state=IDLE. Sweep =
//    (X_MAX+1)*(Y_MAX+1) consecutive plot cycles.
//  - Counters widths 8 bit; X_MAX,Y_MAX <= 255; wrap x->0 at X_MAX, no overflow.
// CONFIGURATION
//  PLOT_CLIP_EN defined: transfer with x>X_MAX or y>Y_MAX still accepted (ready=1,
//    pointer updates) but plot stays 0 next cycle; outputs hold.
//  PLOT_CLIP_EN undefined: all accepted pixels plotted unmodified.
// TESTING
//  1 reset, req0_valid=1 (10,20,0x3F) -> req0_ready=1; next cycle plot=1, x=10,
//    y=20, color_draw=0x3F, grant_id=0.
//  2 req0,req1 both valid 4 cycles -> grants 0,1,0,1; plot high 4 consecutive cycles.
//  3 clear_start=1, clear_color=0x00, req1_valid=1 same cycle -> req1_ready=0;
//    19200 plot cycles (0,0)..(159,119); clear_done pulse once; then req1 served.
//  4 reset asserted at sweep pixel 500 -> next cycle plot=0, clear_busy=0, no
//    clear_done; req0 then accepted normally.
//  5 PLOT_CLIP_EN: req1 (200,5,0xE0) -> req1_ready=1, plot stays 0; without
//    macro plot=1, x=200.
//  6 clear_start held high through sweep -> exactly one sweep, then a second
//    starts the cycle after clear_done's IDLE cycle samples clear_start.

Source files
------------

// File: rtl/plot_arbiter_if.sv
// Pixel write bus shared by two requesters, the clear sweep and the framebuffer.
// master = requester/control side, slave = arbiter.
interface plot_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_x;
  logic [7:0] req0_y;
  logic [7:0] req0_color;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_x;
  logic [7:0] req1_y;
  logic [7:0] req1_color;
  logic       req1_ready;
  logic       clear_start;
  logic [7:0] clear_color;
  logic       clear_busy;
  logic       clear_done;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] color_draw;
  logic       plot;
  logic       grant_id;

  modport master (
    output req0_valid, req0_x, req0_y, req0_color,
    output req1_valid, req1_x, req1_y, req1_color,
    output clear_start, clear_color,
    input  req0_ready, req1_ready,
    input  clear_busy, clear_done,
    input  x, y, color_draw, plot, grant_id
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_color,
    input  req1_valid, req1_x, req1_y, req1_color,
    input  clear_start, clear_color,
    output req0_ready, req1_ready,
    output clear_busy, clear_done,
    output x, y, color_draw, plot, grant_id
  );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin framebuffer write-port arbiter with full-screen clear sweep.
// Optional macro PLOT_CLIP_EN drops accepted pixels outside the screen.
module plot_arbiter #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input logic           clk,
  input logic           reset,
  plot_arbiter_if.slave bus
);

  localparam logic [7:0] XM = X_MAX[7:0];
  localparam logic [7:0] YM = Y_MAX[7:0];

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     r_state, w_state;
  logic [7:0] r_x, r_y, r_color;
  logic [7:0] w_x, w_y, w_color;
  logic       r_plot, r_gid, r_busy, r_done, r_last;
  logic       w_plot, w_gid, w_busy, w_done, w_last;
  logic       w_open, w_rdy0, w_rdy1, w_clip;
  logic [7:0] w_px, w_py, w_pc;

  // r_last holds the id granted most recently; a tie goes to the other one
  always_comb begin
    w_open = (r_state == IDLE) && !bus.clear_start;
    w_rdy0 = w_open && bus.req0_valid
             && (!bus.req1_valid || r_last);
    w_rdy1 = w_open && bus.req1_valid
             && (!bus.req0_valid || !r_last);
    w_px   = w_rdy1 ? bus.req1_x     : bus.req0_x;
    w_py   = w_rdy1 ? bus.req1_y     : bus.req0_y;
    w_pc   = w_rdy1 ? bus.req1_color : bus.req0_color;
`ifdef PLOT_CLIP_EN
    w_clip = (w_px > XM) || (w_py > YM);
`else
    w_clip = 1'b0;
`endif
  end

  // The output coordinate register doubles as the sweep position
  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_color = r_color;
    w_plot  = 1'b0;
    w_gid   = r_gid;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_last  = r_last;
    unique case (r_state)
      IDLE: begin
        if (bus.clear_start) begin
          w_state = CLEAR;
          w_busy  = 1'b1;
          w_x     = 8'd0;
          w_y     = 8'd0;
          w_color = bus.clear_color;
          w_plot  = 1'b1;
        end else if (w_rdy0 || w_rdy1) begin
          w_last = w_rdy1;
          if (!w_clip) begin
            w_x     = w_px;
            w_y     = w_py;
            w_color = w_pc;
            w_plot  = 1'b1;
            w_gid   = w_rdy1;
          end
        end
      end
      CLEAR: begin
        if (r_x == XM && r_y == YM) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_plot = 1'b1;
          if (r_x == XM) begin
            w_x = 8'd0;
            w_y = r_y + 8'd1;
          end else begin
            w_x = r_x + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_color <= 8'd0;
      r_plot  <= 1'b0;
      r_gid   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_color <= w_color;
      r_plot  <= w_plot;
      r_gid   <= w_gid;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_last  <= w_last;
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.color_draw = r_color;
  assign bus.plot       = r_plot;
  assign bus.grant_id   = r_gid;
  assign bus.clear_busy = r_busy;
  assign bus.clear_done = r_done;

endmodule

// File: tb/tb_plot_arbiter.sv
// Testbench for plot_arbiter: directed scenarios plus randomized
// arbitration against a rule-level reference model.
module tb_plot_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  plot_arbiter_if bus();

  plot_arbiter #(.X_MAX(159), .Y_MAX(119)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic idle_inputs;
    bus.req0_valid  = 1'b0;
    bus.req0_x      = 8'd0;
    bus.req0_y      = 8'd0;
    bus.req0_color  = 8'd0;
    bus.req1_valid  = 1'b0;
    bus.req1_x      = 8'd0;
    bus.req1_y      = 8'd0;
    bus.req1_color  = 8'd0;
    bus.clear_start = 1'b0;
    bus.clear_color = 8'd0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({bus.x, bus.y, bus.color_draw, bus.plot, bus.grant_id,
         bus.clear_busy, bus.clear_done} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got x=%0d y=%0d c=%h p=%b g=%b b=%b d=%b want all 0",
               bus.x, bus.y, bus.color_draw, bus.plot, bus.grant_id,
               bus.clear_busy, bus.clear_done);
    end
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_x     = 8'd10;
    bus.req0_y     = 8'd20;
    bus.req0_color = 8'h3F;
    #1;
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ready got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id}
        !== {1'b1, 8'd10, 8'd20, 8'h3F, 1'b0}) begin
      n_fail++;
      $display("FAIL single_out got p=%b x=%0d y=%0d c=%h g=%b want 1,10,20,3f,0",
               bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id);
    end
    bus.req0_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.plot, bus.x} !== {1'b0, 8'd10}) begin
      n_fail++;
      $display("FAIL single_hold got p=%b x=%0d want 0,10", bus.plot, bus.x);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    bus.req0_x = 8'd1; bus.req0_y = 8'd11; bus.req0_color = 8'h11;
    bus.req1_x = 8'd2; bus.req1_y = 8'd22; bus.req1_color = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_tests++;
        if ({bus.plot, bus.grant_id, bus.x} !==
            {1'b1, 1'((k - 1) % 2), 8'(((k - 1) % 2) + 1)}) begin
          n_fail++;
          $display("FAIL rr_out%0d got p=%b g=%b x=%0d want 1,%0d,%0d",
                   k - 1, bus.plot, bus.grant_id, bus.x, (k - 1) % 2, ((k - 1) % 2) + 1);
        end
      end
      if (k == 4) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else begin
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_tests++;
        if ({bus.req0_ready, bus.req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_ready%0d got %b%b want grant %0d",
                   k, bus.req0_ready, bus.req1_ready, k % 2);
        end
      end
    end
  endtask

  task automatic test_clear;
    int bad = 0;
    int dn = 0;
    @(negedge clk);
    bus.clear_color = 8'h00;
    bus.clear_start = 1'b1;
    bus.req1_valid  = 1'b1;
    bus.req1_x      = 8'd7;
    bus.req1_y      = 8'd8;
    bus.req1_color  = 8'h55;
    #1;
    n_tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_blocks_req got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      if (bus.plot !== 1'b1 || bus.x !== 8'(i % 160) || bus.y !== 8'(i / 160)
          || bus.color_draw !== 8'h00 || bus.clear_busy !== 1'b1
          || bus.req1_ready !== 1'b0) bad++;
      if (bus.clear_done === 1'b1) dn++;
      bus.clear_start = 1'b0;
    end
    n_tests++;
    if (bad != 0 || dn != 0) begin
      n_fail++;
      $display("FAIL clear_sweep got bad=%0d early_done=%0d want 0,0", bad, dn);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.plot, bus.clear_busy, bus.clear_done} !== 3'b001) begin
      n_fail++;
      $display("FAIL clear_end got p=%b b=%b d=%b want 0,0,1",
               bus.plot, bus.clear_busy, bus.clear_done);
    end
    n_tests++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_then_ready got %b want 1", bus.req1_ready);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id, bus.clear_done}
        !== {1'b1, 8'd7, 8'd8, 8'h55, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_then_req1 got p=%b x=%0d y=%0d c=%h g=%b d=%b want 1,7,8,55,1,0",
               bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id, bus.clear_done);
    end
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_sweep;
    int dn = 0;
    @(negedge clk);
    bus.clear_color = 8'h1C;
    bus.clear_start = 1'b1;
    for (int i = 0; i <= 500; i++) begin
      @(negedge clk);
      bus.clear_start = 1'b0;
    end
    n_tests++;
    if ({bus.plot, bus.x, bus.y} !== {1'b1, 8'd20, 8'd3}) begin
      n_fail++;
      $display("FAIL mid_pixel500 got p=%b x=%0d y=%0d want 1,20,3", bus.plot, bus.x, bus.y);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({bus.plot, bus.clear_busy, bus.clear_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_abort got p=%b b=%b d=%b want 0,0,0",
               bus.plot, bus.clear_busy, bus.clear_done);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.clear_done !== 1'b0 || bus.plot !== 1'b0) dn++;
    end
    n_tests++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL mid_no_done got %0d bad cycles want 0", dn);
    end
    bus.req0_valid = 1'b1;
    bus.req0_x     = 8'd3;
    bus.req0_y     = 8'd4;
    bus.req0_color = 8'h77;
    #1;
    n_tests++;
    if (bus.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req0_ready got %b want 1", bus.req0_ready);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id}
        !== {1'b1, 8'd3, 8'd4, 8'h77, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_req0_out got p=%b x=%0d y=%0d c=%h g=%b want 1,3,4,77,0",
               bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id);
    end
    bus.req0_valid = 1'b0;
  endtask

  task automatic test_clip;
    logic [7:0] prev_x;
    @(negedge clk);
    prev_x         = bus.x;
    bus.req1_valid = 1'b1;
    bus.req1_x     = 8'd200;
    bus.req1_y     = 8'd5;
    bus.req1_color = 8'hE0;
    #1;
    n_tests++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_ready got %b want 1", bus.req1_ready);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    n_tests++;
`ifdef PLOT_CLIP_EN
    if ({bus.plot, bus.x} !== {1'b0, prev_x}) begin
      n_fail++;
      $display("FAIL clip_drop got p=%b x=%0d want 0,%0d", bus.plot, bus.x, prev_x);
    end
`else
    if ({bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id}
        !== {1'b1, 8'd200, 8'd5, 8'hE0, 1'b1}) begin
      n_fail++;
      $display("FAIL clip_pass got p=%b x=%0d y=%0d c=%h g=%b want 1,200,5,e0,1 (prev x %0d)",
               bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id, prev_x);
    end
`endif
  endtask

  task automatic test_clear_held;
    int bad = 0;
    int dn = 0;
    @(negedge clk);
    bus.clear_color = 8'hA5;
    bus.clear_start = 1'b1;
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      if (bus.plot !== 1'b1 || bus.x !== 8'(i % 160) || bus.y !== 8'(i / 160)
          || bus.color_draw !== 8'hA5) bad++;
      if (bus.clear_done === 1'b1) dn++;
    end
    n_tests++;
    if (bad != 0 || dn != 0) begin
      n_fail++;
      $display("FAIL held_sweep got bad=%0d early_done=%0d want 0,0", bad, dn);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.plot, bus.clear_busy, bus.clear_done} !== 3'b001) begin
      n_fail++;
      $display("FAIL held_gap got p=%b b=%b d=%b want 0,0,1",
               bus.plot, bus.clear_busy, bus.clear_done);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.plot, bus.x, bus.y, bus.color_draw, bus.clear_busy, bus.clear_done}
        !== {1'b1, 8'd0, 8'd0, 8'hA5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL held_restart got p=%b x=%0d y=%0d c=%h b=%b d=%b want 1,0,0,a5,1,0",
               bus.plot, bus.x, bus.y, bus.color_draw, bus.clear_busy, bus.clear_done);
    end
    bus.clear_start = 1'b0;
    do_reset();
  endtask

  task automatic test_random;
    int         last = 1;
    int         win;
    logic [7:0] ex = 8'd0, ey = 8'd0, ec = 8'd0;
    logic       ep = 1'b0, eg = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0;
    logic [7:0] x0 = 8'd0, y0 = 8'd0, c0 = 8'd0;
    logic [7:0] x1 = 8'd0, y1 = 8'd0, c1 = 8'd0;
    logic       drop;
    do_reset();
    for (int c = 0; c <= 400; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id} !== {ep, ex, ey, ec, eg}) begin
        n_fail++;
        $display("FAIL rand_out%0d got p=%b x=%0d y=%0d c=%h g=%b want %b,%0d,%0d,%h,%b",
                 c, bus.plot, bus.x, bus.y, bus.color_draw, bus.grant_id, ep, ex, ey, ec, eg);
      end
      if (c == 400) break;
      if (!v0 || acc0) begin
        v0 = ($urandom % 3) != 0;
        x0 = 8'($urandom_range(0, 200));
        y0 = 8'($urandom_range(0, 140));
        c0 = 8'($urandom);
      end
      if (!v1 || acc1) begin
        v1 = ($urandom % 3) != 0;
        x1 = 8'($urandom_range(0, 200));
        y1 = 8'($urandom_range(0, 140));
        c1 = 8'($urandom);
      end
      bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0; bus.req0_color = c0;
      bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1; bus.req1_color = c1;
      #1;
      if (v0 && v1) win = 1 - last;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
      else          win = -1;
      n_tests++;
      if ({bus.req0_ready, bus.req1_ready} !== {win == 0, win == 1}) begin
        n_fail++;
        $display("FAIL rand_ready%0d got %b%b want winner %0d",
                 c, bus.req0_ready, bus.req1_ready, win);
      end
      acc0 = (win == 0);
      acc1 = (win == 1);
      ep = 1'b0;
      if (win >= 0) begin
        last = win;
`ifdef PLOT_CLIP_EN
        drop = (win == 0) ? (x0 > 159 || y0 > 119) : (x1 > 159 || y1 > 119);
`else
        drop = 1'b0;
`endif
        if (!drop) begin
          ep = 1'b1;
          eg = (win == 1);
          ex = (win == 1) ? x1 : x0;
          ey = (win == 1) ? y1 : y0;
          ec = (win == 1) ? c1 : c0;
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_clear();
    test_reset_mid_sweep();
    test_clip();
    test_clear_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
